toy_mem_arbiter: RTL and testbench
==================================

Name: toy_mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port toy_mem_model_bit instance among NUM_REQ requesters (e.g. icache refill, prefetch, testbench backdoor).
- Each requester has a valid/ready command channel and a valid/ready read-response channel.
- The block drives the memory's en/addr/wr_en/wr_data pins from registers and returns mem rd_data to the requester that issued the read.
- One access is in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, memory word-address width.
- DATA_WIDTH, 32, memory data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_vld  input  NUM_REQ  per-requester command valid.
- req_rdy  output  NUM_REQ  per-requester command accept.
- req_wr_en  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wr_data  input  NUM_REQ*DATA_WIDTH  packed write data.
- resp_vld  output  NUM_REQ  read data valid.
- resp_rdy  input  NUM_REQ  read data accept.
- resp_data  output  DATA_WIDTH  shared read data; meaningful only where resp_vld is set.
- mem_en  output  1  to memory en.
- mem_wr_en  output  1  to memory wr_en.
- mem_addr  output  ADDR_WIDTH  to memory addr.
- mem_wr_data  output  DATA_WIDTH  to memory wr_data.
- mem_rd_data  input  DATA_WIDTH  from memory rd_data.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = 0; grant register = 0.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronous).
  - Any in-flight access and any pending response are dropped.
- FSM states and transitions:
  - IDLE:
    - Select the first i with req_vld[i]=1, searching from the pointer upward with wrap.
    - req_rdy[i]=1 only for that i, combinationally, and only in IDLE. All other req_rdy are 0.
    - On handshake: latch grant, wr_en, addr, wr_data; pointer <= (i+1) mod NUM_REQ; go ISSUE.
    - No req_vld set: stay in IDLE.
  - ISSUE:
    - mem_en=1 for exactly this cycle; mem_wr_en/mem_addr/mem_wr_data come from the latched command.
    - Write: go IDLE.
    - Read: go WAIT.
  - WAIT:
    - mem_en=0.
    - The memory updated rd_data at the edge that ended ISSUE.
    - Capture mem_rd_data into the resp_data register at the end of WAIT (this avoids a same-edge race); go RESP.
  - RESP:
    - resp_vld[grant]=1; resp_data held stable.
    - On resp_rdy[grant]=1: clear resp_vld; go IDLE.
    - resp_rdy on other indices is ignored.
- Latency:
  - Read: handshake in cycle T, mem_en in T+1, resp_vld in T+3 at the earliest.
  - Write: handshake T, mem_en T+1, next grant possible in T+2.
- Throughput: one write per 2 cycles; one read per 4 cycles under zero backpressure.
- mem_en is never asserted outside ISSUE, and mem_en is high for at most one cycle per grant.
- mem_addr/mem_wr_data/mem_wr_en hold their last values when mem_en=0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- A requester may drop req_vld before its handshake; nothing is latched in that case.
- Simultaneous resp_rdy and a new req_vld: the response completes in RESP and the new command is arbitrated in the following IDLE cycle.

Optional Feature:
- Macro: TOY_MEM_ARB_STAT_EN.
- Defined:
  - Adds outputs stat_rd_cnt and stat_wr_cnt, each NUM_REQ*32 packed.
  - Counters are saturating, one per requester.
  - A counter increments in the ISSUE cycle according to the latched type and grant.
  - Counters reset to 0.
  - Also adds a $display of "[ARB][rd|wr] req=%0d addr=%h" on each ISSUE when +DEBUG is present.
- Undefined: no stat ports, no counter logic, no display.

Test Plan:
- Single read: preload mem[0x10]=0xDEADBEEF; req0 reads 0x10 with resp_rdy=1 → mem_en pulses one cycle with addr 0x10, wr_en 0; resp_vld[0] 3 cycles after handshake; resp_data=0xDEADBEEF.
- Write then read: req1 writes 0xCAFEF00D to 0x20, then reads 0x20 → mem_wr_en=1 during the write ISSUE; the read returns 0xCAFEF00D on resp_vld[1].
- Contention: req0 and req1 both hold valid for 6 reads each → grants alternate 0,1,0,1…; no back-to-back grant to the same index while the other is valid.
- Backpressure: req0 read with resp_rdy[0]=0 for 5 cycles → resp_vld[0] and resp_data stay stable; req_rdy stays 0 for every requester until resp_rdy[0]=1; IDLE is reached the next cycle.
- Reset mid-read: assert rst during WAIT → mem_en, resp_vld, req_rdy go 0 immediately; after release, a new read from req1 completes normally and the pointer restarts at 0.
- Unread address: read 0x3FF never written → resp_data=0 and resp_vld behaves as for a normal read.

Source files
------------

// File: rtl/toy_mem_arbiter_if.sv
// Requester command/response channels and memory-side pins shared by toy_mem_arbiter.
// The stat counter buses exist only when TOY_MEM_ARB_STAT_EN is defined.
interface toy_mem_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ-1:0]            req_rdy;
  logic [NUM_REQ-1:0]            req_wr_en;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data;
  logic [NUM_REQ-1:0]            resp_vld;
  logic [NUM_REQ-1:0]            resp_rdy;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          mem_en;
  logic                          mem_wr_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wr_data;
  logic [DATA_WIDTH-1:0]         mem_rd_data;
`ifdef TOY_MEM_ARB_STAT_EN
  logic [NUM_REQ*32-1:0]         stat_rd_cnt;
  logic [NUM_REQ*32-1:0]         stat_wr_cnt;

  modport slave (
    input  req_vld, req_wr_en, req_addr, req_wr_data, resp_rdy, mem_rd_data,
    output req_rdy, resp_vld, resp_data, mem_en, mem_wr_en, mem_addr, mem_wr_data,
    output stat_rd_cnt, stat_wr_cnt
  );

  modport master (
    output req_vld, req_wr_en, req_addr, req_wr_data, resp_rdy, mem_rd_data,
    input  req_rdy, resp_vld, resp_data, mem_en, mem_wr_en, mem_addr, mem_wr_data,
    input  stat_rd_cnt, stat_wr_cnt
  );
`else
  modport slave (
    input  req_vld, req_wr_en, req_addr, req_wr_data, resp_rdy, mem_rd_data,
    output req_rdy, resp_vld, resp_data, mem_en, mem_wr_en, mem_addr, mem_wr_data
  );

  modport master (
    output req_vld, req_wr_en, req_addr, req_wr_data, resp_rdy, mem_rd_data,
    input  req_rdy, resp_vld, resp_data, mem_en, mem_wr_en, mem_addr, mem_wr_data
  );
`endif
endinterface

// File: rtl/toy_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters, one access in flight.
// Optional per-requester saturating read/write counters under TOY_MEM_ARB_STAT_EN.
module toy_mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  toy_mem_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [IDX_W:0]   cand;

  // First valid requester at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!sel_found && bus.req_vld[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    bus.req_rdy = '0;
    if (!rst && state == IDLE && sel_found)
      bus.req_rdy[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      grant           <= '0;
      bus.mem_en      <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      bus.resp_vld    <= '0;
      bus.resp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant           <= sel_idx;
            ptr             <= (sel_idx == IDX_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
            bus.mem_en      <= 1'b1;
            bus.mem_wr_en   <= bus.req_wr_en[sel_idx];
            bus.mem_addr    <= bus.req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_wr_data <= bus.req_wr_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          state      <= bus.mem_wr_en ? IDLE : WAIT;
        end
        WAIT: begin
          // rd_data settled at the edge that ended ISSUE, so it is safe to sample here.
          bus.resp_data <= bus.mem_rd_data;
          bus.resp_vld  <= NUM_REQ'(1) << grant;
          state         <= RESP;
        end
        RESP: begin
          if (bus.resp_rdy[grant]) begin
            bus.resp_vld <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TOY_MEM_ARB_STAT_EN
  logic [31:0] rd_cnt [NUM_REQ];
  logic [31:0] wr_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_cnt[i] <= '0;
        wr_cnt[i] <= '0;
      end
    end else if (state == ISSUE) begin
      if (bus.mem_wr_en) begin
        if (wr_cnt[grant] != '1)
          wr_cnt[grant] <= wr_cnt[grant] + 32'd1;
      end else begin
        if (rd_cnt[grant] != '1)
          rd_cnt[grant] <= rd_cnt[grant] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign bus.stat_rd_cnt[g*32 +: 32] = rd_cnt[g];
    assign bus.stat_wr_cnt[g*32 +: 32] = wr_cnt[g];
  end

`ifdef DEBUG
  always @(posedge clk) begin
    if (!rst && state == ISSUE)
      $display("[ARB][%s] req=%0d addr=%h", bus.mem_wr_en ? "wr" : "rd", grant, bus.mem_addr);
  end
`endif
`endif

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Directed bench for toy_mem_arbiter with a behavioural single-port memory
// that updates rd_data on the clock edge that samples mem_en.
module tb_toy_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;

  logic clk = 1'b0;
  logic rst;
  logic mem_clear;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   cnt0, cnt1, exp_idx;

  logic [DW-1:0] mem_array [0:1023];

  toy_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  toy_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: clear plus preload while mem_clear is high, else one access per mem_en.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem_array[i] <= '0;
      mem_array[10'h010] <= 32'hDEADBEEF;
    end else if (bus.mem_en) begin
      if (bus.mem_wr_en) mem_array[bus.mem_addr[9:0]] <= bus.mem_wr_data;
      else               bus.mem_rd_data <= mem_array[bus.mem_addr[9:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic vld, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_vld[idx]                = vld;
    bus.req_wr_en[idx]              = wr;
    bus.req_addr[idx*AW +: AW]      = addr;
    bus.req_wr_data[idx*DW +: DW]   = data;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_cnt++;
    assert (observed === expected)
    else begin
      bad_cnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst             = 1'b1;
    mem_clear       = 1'b1;
    bus.req_vld     = '0;
    bus.req_wr_en   = '0;
    bus.req_addr    = '0;
    bus.req_wr_data = '0;
    bus.resp_rdy    = '0;
    tick();
    tick();
    checkOutput("rst_mem_en",    bus.mem_en, 0);
    checkOutput("rst_req_rdy",   bus.req_rdy, 0);
    checkOutput("rst_resp_vld",  bus.resp_vld, 0);
    checkOutput("rst_resp_data", bus.resp_data, 0);
    checkOutput("rst_mem_addr",  bus.mem_addr, 0);
    mem_clear = 1'b0;
    rst       = 1'b0;
    tick();

    $display("[TB] single read");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
    bus.resp_rdy = 2'b11;
    #1;
    checkOutput("rd_req_rdy", bus.req_rdy, 2'b01);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
    checkOutput("rd_issue_en",   bus.mem_en, 1);
    checkOutput("rd_issue_addr", bus.mem_addr, 32'h10);
    checkOutput("rd_issue_wr",   bus.mem_wr_en, 0);
    checkOutput("rd_issue_rdy",  bus.req_rdy, 0);
    tick();
    checkOutput("rd_wait_en",  bus.mem_en, 0);
    checkOutput("rd_wait_vld", bus.resp_vld, 0);
    tick();
    checkOutput("rd_resp_vld",  bus.resp_vld, 2'b01);
    checkOutput("rd_resp_data", bus.resp_data, 32'hDEADBEEF);
    tick();
    checkOutput("rd_done_vld", bus.resp_vld, 0);

    $display("[TB] write then read on requester 1");
    applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    #1;
    checkOutput("wr_req_rdy", bus.req_rdy, 2'b10);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    checkOutput("wr_issue_en",   bus.mem_en, 1);
    checkOutput("wr_issue_wr",   bus.mem_wr_en, 1);
    checkOutput("wr_issue_addr", bus.mem_addr, 32'h20);
    checkOutput("wr_issue_data", bus.mem_wr_data, 32'hCAFEF00D);
    checkOutput("wr_issue_rdy",  bus.req_rdy, 0);
    tick();
    checkOutput("wr_idle_rdy",  bus.req_rdy, 2'b10);
    checkOutput("wr_idle_en",   bus.mem_en, 0);
    checkOutput("wr_hold_wr",   bus.mem_wr_en, 1);
    checkOutput("wr_hold_addr", bus.mem_addr, 32'h20);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 32'h20, 32'h0);
    checkOutput("wrrd_issue_en", bus.mem_en, 1);
    checkOutput("wrrd_issue_wr", bus.mem_wr_en, 0);
    tick();
    tick();
    checkOutput("wrrd_resp_vld",  bus.resp_vld, 2'b10);
    checkOutput("wrrd_resp_data", bus.resp_data, 32'hCAFEF00D);
    tick();

    $display("[TB] contention, six reads each");
    cnt0 = 0;
    cnt1 = 0;
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int g = 0; g < 12; g++) begin
      exp_idx = g % 2;
      #1;
      checkOutput("ct_req_rdy", bus.req_rdy, (exp_idx == 0) ? 2'b01 : 2'b10);
      tick();
      if (exp_idx == 0) begin
        cnt0++;
        if (cnt0 == 6) applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
      end else begin
        cnt1++;
        if (cnt1 == 6) applyStimulus(1, 1'b0, 1'b0, 32'h20, 32'h0);
      end
      checkOutput("ct_issue_en",   bus.mem_en, 1);
      checkOutput("ct_issue_addr", bus.mem_addr, (exp_idx == 0) ? 32'h10 : 32'h20);
      tick();
      checkOutput("ct_wait_en", bus.mem_en, 0);
      tick();
      checkOutput("ct_resp_vld",  bus.resp_vld, (exp_idx == 0) ? 2'b01 : 2'b10);
      checkOutput("ct_resp_data", bus.resp_data, (exp_idx == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
      tick();
    end

    $display("[TB] backpressure on requester 0");
    bus.resp_rdy = 2'b10;
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    checkOutput("bp_req_rdy", bus.req_rdy, 2'b01);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_hold_vld",  bus.resp_vld, 2'b01);
      checkOutput("bp_hold_data", bus.resp_data, 32'hDEADBEEF);
      checkOutput("bp_hold_rdy",  bus.req_rdy, 0);
      tick();
    end
    bus.resp_rdy = 2'b11;
    #1;
    checkOutput("bp_last_vld", bus.resp_vld, 2'b01);
    tick();
    checkOutput("bp_idle_vld", bus.resp_vld, 0);
    checkOutput("bp_idle_rdy", bus.req_rdy, 2'b10);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 32'h20, 32'h0);
    tick();
    tick();
    checkOutput("bp_r1_vld",  bus.resp_vld, 2'b10);
    checkOutput("bp_r1_data", bus.resp_data, 32'hCAFEF00D);
    tick();

    $display("[TB] unread address");
    applyStimulus(0, 1'b1, 1'b0, 32'h3FF, 32'h0);
    #1;
    checkOutput("ur_req_rdy", bus.req_rdy, 2'b01);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h3FF, 32'h0);
    checkOutput("ur_issue_addr", bus.mem_addr, 32'h3FF);
    tick();
    tick();
    checkOutput("ur_resp_vld",  bus.resp_vld, 2'b01);
    checkOutput("ur_resp_data", bus.resp_data, 0);
    tick();

    $display("[TB] reset during WAIT");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("rs_req_rdy", bus.req_rdy, 2'b01);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
    checkOutput("rs_issue_addr", bus.mem_addr, 32'h10);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rs_mem_en",   bus.mem_en, 0);
    checkOutput("rs_resp_vld", bus.resp_vld, 0);
    checkOutput("rs_req_rdy0", bus.req_rdy, 0);
    checkOutput("rs_mem_addr", bus.mem_addr, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rs_ptr_zero", bus.req_rdy, 2'b01);
    applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("rs_drop_rdy", bus.req_rdy, 2'b10);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 32'h20, 32'h0);
    checkOutput("rs_issue_en",   bus.mem_en, 1);
    checkOutput("rs_issue_addr", bus.mem_addr, 32'h20);
    tick();
    tick();
    checkOutput("rs_resp_vld",  bus.resp_vld, 2'b10);
    checkOutput("rs_resp_data", bus.resp_data, 32'hCAFEF00D);
    tick();
    checkOutput("rs_done_vld", bus.resp_vld, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
